// File: rtl/uart_loader_ctrl_pkg.sv
// rtl/uart_loader_ctrl_pkg.sv - shared types and constants for the UART boot loader
package uart_loader_ctrl_pkg;

  localparam int WORD_WIDTH = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DAT_LO,
    DAT_HI,
    CS_LO,
    CS_HI,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/uart_loader_ctrl_if.sv
// rtl/uart_loader_ctrl_if.sv - received byte stream and memory write port bundle
interface uart_loader_ctrl_if;
  import uart_loader_ctrl_pkg::*;

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  mem_sel;
  logic                  mem_we;
  logic [WORD_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;

  // Loader side: consumes UART bytes, drives the memory write port.
  modport master (
    input  byte_valid, byte_data,
    output mem_sel, mem_we, mem_addr, mem_wdata
  );

  // Environment side: UART receiver and memory.
  modport slave (
    output byte_valid, byte_data,
    input  mem_sel, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/uart_loader_ctrl_idle_timer.sv
// rtl/uart_loader_ctrl_idle_timer.sv - inter-byte idle counter with clear, enable and expiry
module idle_timer #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == LAST);

  // Clear has priority; otherwise count while enabled and saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_loader_ctrl.sv
// rtl/uart_loader_ctrl.sv - UART frame loader writing a boot image into memory
module uart_loader_ctrl
  import uart_loader_ctrl_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR      = 16'h0000,
  parameter logic [WORD_WIDTH-1:0] MAX_WORDS      = 16'd1024,
  parameter int unsigned           TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_loader_ctrl_if.master     bus,
  input  logic                   rearm,
  output logic                   cpu_rst_n,
  output logic                   busy,
  output logic                   load_done,
  output logic                   error,
  output logic [WORD_WIDTH-1:0]  word_count
);

  state_t                state_q, state_d;
  logic [7:0]            lo_q, lo_d;
  logic [WORD_WIDTH-1:0] len_q, len_d;
  logic [WORD_WIDTH-1:0] csum_q, csum_d;
  logic [WORD_WIDTH-1:0] word_count_q, word_count_d;
  logic                  mem_we_q, mem_we_d;
  logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  load_done_q, load_done_d;
  logic                  error_q, error_d;

  logic                  bv;
  logic [WORD_WIDTH-1:0] word_in;
  logic                  tmr_expire;

  assign bv      = bus.byte_valid;
  assign word_in = {bus.byte_data, lo_q};
  assign busy    = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);

  // The idle counter only matters mid-frame; any byte restarts the window.
  idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (bv || !busy),
    .en     (busy),
    .expire (tmr_expire)
  );

  // Frame parser: next state, word assembly, checksum and memory write request.
  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    len_d        = len_q;
    csum_d       = csum_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    load_done_d  = load_done_q;
    error_d      = error_q;

    case (state_q)
      IDLE: begin
        if (bv && (bus.byte_data == SYNC_BYTE)) begin
          state_d      = LEN_LO;
          csum_d       = '0;
          word_count_d = '0;
        end
      end
      LEN_LO: if (bv) begin lo_d = bus.byte_data; state_d = LEN_HI; end
      DAT_LO: if (bv) begin lo_d = bus.byte_data; state_d = DAT_HI; end
      CS_LO:  if (bv) begin lo_d = bus.byte_data; state_d = CS_HI;  end
      LEN_HI: begin
        if (bv) begin
          len_d = word_in;
          if (word_in == '0) begin
            state_d = CS_LO;
          end else if (word_in > MAX_WORDS) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            state_d = DAT_LO;
          end
        end
      end
      DAT_HI: begin
        if (bv) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = BASE_ADDR + word_count_q;
          mem_wdata_d  = word_in;
          word_count_d = word_count_q + 1'b1;
          csum_d       = csum_q + word_in;
          state_d      = ((word_count_q + 1'b1) == len_q) ? CS_LO : DAT_LO;
        end
      end
      CS_HI: begin
        if (bv) begin
          if (word_in == csum_q) begin
            state_d     = DONE;
            load_done_d = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
      DONE, ERROR: begin
        if (rearm) begin
          state_d      = IDLE;
          word_count_d = '0;
          load_done_d  = 1'b0;
          error_d      = 1'b0;
          cpu_rst_n_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte on the expiry cycle wins, so only a silent expiry aborts the frame.
    if (tmr_expire && !bv) begin
      state_d = ERROR;
      error_d = 1'b1;
    end
  end

  // State and datapath registers; reset drops any partially received word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lo_q         <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_n_q  <= 1'b0;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      word_count_q <= word_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
    end
  end

  assign bus.mem_sel   = ~load_done_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign load_done     = load_done_q;
  assign error         = error_q;
  assign word_count    = word_count_q;

endmodule

// File: doc/uart_loader_ctrl.md
UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: memory address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 16'd1024: largest accepted length field.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles allowed between bytes once a frame has started.
REQ-004 Port clk  in  1: system clock; all logic is rising-edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-low.
REQ-006 Port byte_valid  in  1: single-cycle pulse, synchronous to clk; qualifies byte_data.
REQ-007 Port byte_data  in  8: received UART byte.
REQ-008 Port rearm  in  1: single-cycle pulse; leaves DONE or ERROR and returns to IDLE.
REQ-009 Port mem_sel  out  1: loader owns the memory write port.
REQ-010 Port mem_we, mem_addr, mem_wdata  out  1/WORD_WIDTH/WORD_WIDTH: memory write strobe, address and data.
REQ-011 Port cpu_rst_n  out  1: CPU reset, active-low; held low while loading.
REQ-012 Port busy, load_done, error  out  1/1/1: status flags.
REQ-013 Port word_count  out  WORD_WIDTH: number of data words written in the current frame.

Function
REQ-014 Frame format: sync byte 8'hA5, LEN (2 bytes), LEN data words (2 bytes each), CSUM (2 bytes); every word is sent low byte first.
REQ-015 The state machine SHALL have the states IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CS_LO, CS_HI, DONE, ERROR.
REQ-016 State transitions:
- IDLE: a byte of 8'hA5 moves to LEN_LO; any other byte is ignored.
- Each _LO state moves to its _HI state on a byte.
- LEN_HI moves to DAT_LO, or to CS_LO when LEN==0, or to ERROR when LEN>MAX_WORDS.
- DAT_HI moves to CS_LO after the last word, otherwise back to DAT_LO.
- CS_HI moves to DONE on a checksum match, otherwise to ERROR.
REQ-017 On the byte_valid that completes a data word, mem_we SHALL pulse high for exactly one cycle on the next cycle, with mem_addr = BASE_ADDR + word_count (pre-increment value) and mem_wdata = {hi, lo}; word_count increments in that same cycle.
REQ-018 Checksum SHALL be the sum of all data words modulo 2^WORD_WIDTH; the expected value for LEN==0 is 0.
REQ-019 Address arithmetic SHALL wrap modulo 2^WORD_WIDTH with no error.
REQ-020 busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-021 mem_sel SHALL equal ~load_done.
REQ-022 cpu_rst_n SHALL go high on the cycle DONE is entered and SHALL stay high until rearm or rst.
REQ-023 Timeout: the idle counter clears on every byte_valid and runs only while busy; on reaching TIMEOUT_CYCLES-1 the block moves to ERROR.
REQ-024 When byte_valid and timeout expiry occur in the same cycle, the byte SHALL win and the counter clears.
REQ-025 In DONE and ERROR, byte_valid SHALL be ignored; rearm moves to IDLE, clears word_count, load_done and error, and drives cpu_rst_n low.
REQ-026 rearm SHALL be ignored in all states other than DONE and ERROR.
REQ-027 ERROR SHALL set error=1 and keep cpu_rst_n low.
REQ-028 No back-pressure: one byte per byte_valid, and back-to-back byte_valid on consecutive cycles SHALL be accepted.

Reset
REQ-029 On rst low, state SHALL be IDLE and the outputs SHALL be: mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, cpu_rst_n=0, busy=0, load_done=0, error=0, mem_sel=1.
REQ-030 Reset SHALL take effect mid-frame immediately: a partially received word is discarded and no mem_we is issued.
REQ-031 After rst is released, the first byte_valid SHALL be evaluated in IDLE.

Structure
REQ-032 Shared package: the state enum, SYNC_BYTE=8'hA5, and WORD_WIDTH=16 (from defs.vh).
REQ-033 One sub-module, idle_timer: a parameterised counter with clear and enable inputs and an expire output.
REQ-034 Target size is 150-300 lines of RTL; no memories inside the block.

Verification
REQ-035 Frame A5 02 00 34 12 78 56 AC 68 -> mem writes (0000,1234) then (0001,5678); load_done=1, cpu_rst_n=1, word_count=2.
REQ-036 Same frame with CSUM 00 00 -> both words written, then error=1, cpu_rst_n stays 0; rearm -> IDLE, word_count=0.
REQ-037 Bytes 00 FF then A5 00 00 00 00 -> leading bytes ignored, no mem_we, DONE.
REQ-038 LEN=16'h0401 with MAX_WORDS=1024 -> ERROR right after LEN_HI, no mem_we.
REQ-039 Frame stalled after DAT_LO with TIMEOUT_CYCLES=50 -> error at idle cycle 50; a byte arriving on the expiry cycle instead keeps the block in DAT_HI.
REQ-040 rst low during DAT_HI of word 1 -> all outputs at reset values; a following complete frame loads from BASE_ADDR.
